// File: rtl/product_accumulator_if.sv
// Handshake bundle between the upstream multiplier, the accumulator and the byte sink.
// A transfer happens on a rising clk edge where valid && ready are both 1; valid may not depend on ready.
interface product_accumulator_if #(
    parameter int P_W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [P_W-1:0] in_product;
    logic           out_valid;
    logic           out_ready;
    logic [7:0]     out_byte;
    logic           out_last;

    modport master (
        output in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );

    modport slave (
        input  in_valid, in_product, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates unsigned multiplier products (wrapping or saturating) and drains the
// total as two bytes, low first, clearing the accumulator once the high byte is taken.
module product_accumulator #(
    parameter int P_W   = 8,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    product_accumulator_if.slave bus,
    input  logic                 clear,
    input  logic                 sat_en,
    input  logic                 rd_req,
    output logic [ACC_W-1:0]     acc_value,
    output logic [7:0]           count,
    output logic                 overflow,
    output logic [1:0]           fsm_state
);
    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        DRAIN_LO = 2'd1,
        DRAIN_HI = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] snapshot;
    logic             accept;
    logic [ACC_W:0]   raw_sum;
    logic             carry;
    logic [ACC_W-1:0] sum_val;
    logic [ACC_W-1:0] next_acc;

    always_comb begin
        accept   = bus.in_valid && (state == ACCUM);
        raw_sum  = {1'b0, acc} + {{(ACC_W + 1 - P_W){1'b0}}, bus.in_product};
        carry    = raw_sum[ACC_W];
        sum_val  = (carry && sat_en) ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
        // The snapshot must include a product accepted alongside rd_req.
        next_acc = accept ? sum_val : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACCUM;
            acc           <= '0;
            snapshot      <= '0;
            count         <= 8'd0;
            overflow      <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_byte  <= 8'd0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (clear) begin
                        acc      <= '0;
                        count    <= 8'd0;
                        overflow <= 1'b0;
                    end else begin
                        if (accept) begin
                            acc      <= sum_val;
                            count    <= (count == 8'd255) ? count : count + 8'd1;
                            overflow <= overflow | carry;
                        end
                        if (rd_req) begin
                            state         <= DRAIN_LO;
                            snapshot      <= next_acc;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_byte  <= next_acc[7:0];
                            bus.out_last  <= 1'b0;
                        end
                    end
                end
                DRAIN_LO: begin
                    if (bus.out_ready) begin
                        state        <= DRAIN_HI;
                        bus.out_byte <= snapshot[15:8];
                        bus.out_last <= 1'b1;
                    end
                end
                DRAIN_HI: begin
                    // Read-and-clear once the final byte is handed off.
                    if (bus.out_ready) begin
                        state         <= ACCUM;
                        acc           <= '0;
                        count         <= 8'd0;
                        overflow      <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.out_valid <= 1'b0;
                        bus.out_byte  <= 8'd0;
                        bus.out_last  <= 1'b0;
                    end
                end
                default: begin
                    state         <= ACCUM;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.out_byte  <= 8'd0;
                    bus.out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign acc_value = acc;
    assign fsm_state = state;
endmodule

// File: tb/tb_product_accumulator.sv
// Randomized scoreboard bench for product_accumulator: stimulus pushes expected drain
// bytes into a queue, a negedge monitor pops and compares every accepted output byte.
module tb_product_accumulator;
    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        sat_en;
    logic        rd_req;
    logic [15:0] acc_value;
    logic [7:0]  count;
    logic        overflow;
    logic [1:0]  fsm_state;

    product_accumulator_if #(.P_W(8)) bus ();

    product_accumulator #(.P_W(8), .ACC_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .clear     (clear),
        .sat_en    (sat_en),
        .rd_req    (rd_req),
        .acc_value (acc_value),
        .count     (count),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];   // {last, byte}
    int errors = 0;
    int checks = 0;

    // Reference model: plain integer arithmetic on the running total.
    int unsigned model_acc = 0;
    int unsigned model_cnt = 0;
    int unsigned model_ovf = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input int unsigned p);
        int unsigned sum;
        sum = model_acc + p;
        if (sum > 65535) begin
            model_ovf = 1;
            model_acc = sat_en ? 65535 : sum - 65536;
        end else begin
            model_acc = sum;
        end
        if (model_cnt < 255) model_cnt++;
    endtask

    task automatic model_zero();
        model_acc = 0;
        model_cnt = 0;
        model_ovf = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_acc"}, acc_value, model_acc);
        check({tag, "_count"}, count, model_cnt);
        check({tag, "_ovf"}, overflow, model_ovf);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h last=%0b with nothing expected", bus.out_byte, bus.out_last);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("drain_byte", {bus.out_last, bus.out_byte}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic push_product(input logic [7:0] p);
        bus.in_valid   = 1'b1;
        bus.in_product = p;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        model_accept(p);
    endtask

    task automatic do_clear(input bit with_prod, input logic [7:0] p);
        clear          = 1'b1;
        bus.in_valid   = with_prod;
        bus.in_product = p;
        @(posedge clk); #1;
        clear          = 1'b0;
        bus.in_valid   = 1'b0;
        model_zero();
    endtask

    task automatic drain(input bit with_prod, input logic [7:0] p, input int stall);
        int unsigned snap;
        bit done;
        bus.out_ready  = (stall == 0);
        rd_req         = 1'b1;
        bus.in_valid   = with_prod;
        bus.in_product = p;
        @(posedge clk); #1;
        rd_req         = 1'b0;
        bus.in_valid   = 1'b0;
        if (with_prod) model_accept(p);
        snap = model_acc;
        exp_q.push_back({1'b0, snap[7:0]});
        exp_q.push_back({1'b1, snap[15:8]});
        for (int i = 0; i < stall; i++) begin
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_byte", bus.out_byte, snap[7:0]);
            check("stall_in_ready", bus.in_ready, 0);
            // clear, rd_req and products must all be ignored while draining
            clear          = 1'b1;
            rd_req         = 1'b1;
            bus.in_valid   = 1'b1;
            bus.in_product = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
            clear          = 1'b0;
            rd_req         = 1'b0;
            bus.in_valid   = 1'b0;
            check("stall_acc_hold", acc_value, snap);
        end
        bus.out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (!bus.out_valid) done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: out_valid still 1 after 10 cycles");
        end
        model_zero();
    endtask

    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_acc"}, acc_value, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_out_byte"}, bus.out_byte, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        model_zero();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b1;
        clear          = 1'b0;
        sat_en         = 1'b0;
        rd_req         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_product = 8'd0;
        bus.out_ready  = 1'b1;
        @(posedge clk); #1;
        reset_pulse("reset");

        // Accept and drain
        push_product(8'hE1);
        push_product(8'h0C);
        push_product(8'h0C);
        check("basic_acc", acc_value, 16'h00F9);
        check("basic_count", count, 3);
        drain(1'b0, 8'h00, 0);
        check_model("basic_after");
        check("basic_after_zero", acc_value, 0);

        // Wrap versus saturate
        sat_en = 1'b0;
        repeat (258) push_product(8'hFF);
        check("wrap_acc", acc_value, 16'h00FE);
        check("wrap_ovf", overflow, 1);
        check("wrap_count", count, 255);
        check_model("wrap");
        do_clear(1'b0, 8'h00);
        sat_en = 1'b1;
        repeat (258) push_product(8'hFF);
        check("sat_acc", acc_value, 16'hFFFF);
        check("sat_ovf", overflow, 1);
        check_model("sat");
        do_clear(1'b0, 8'h00);
        check_model("cleared");
        sat_en = 1'b0;

        // Simultaneous accept + rd_req, then clear + accept
        push_product(8'h10);
        check("pre_sim_acc", acc_value, 16'h0010);
        drain(1'b1, 8'h05, 0);
        check_model("sim_after");
        push_product(8'h33);
        do_clear(1'b1, 8'h40);
        check("clear_prio_acc", acc_value, 0);
        check("clear_prio_count", count, 0);

        // Backpressure
        push_product(8'hA7);
        push_product(8'h9C);
        drain(1'b0, 8'h00, 3);
        check_model("bp_after");

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            int unsigned op;
            op = $urandom_range(0, 99);
            sat_en = 1'($urandom_range(0, 1));
            if (op < 70) push_product(8'($urandom_range(0, 255)));
            else if (op < 78) do_clear(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            else if (op < 90) drain(1'b0, 8'h00, $urandom_range(0, 3));
            else drain(1'b1, 8'($urandom_range(0, 255)), $urandom_range(0, 3));
            check_model("rand");
        end

        // Reset mid-drain (in DRAIN_HI)
        push_product(8'h5A);
        push_product(8'h77);
        drain_to_hi();
        check("hi_out_last", bus.out_last, 1);
        check("hi_out_valid", bus.out_valid, 1);
        check("hi_out_byte", bus.out_byte, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        void'(exp_q.pop_back());   // the aborted high byte is never sent
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_zero();
        @(posedge clk); #1;
        check("midrst_acc", acc_value, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_bytes", bus.out_valid, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Enter DRAIN_HI and stall there: low byte is taken, high byte is left pending.
    task automatic drain_to_hi();
        int unsigned snap;
        bus.out_ready = 1'b0;
        rd_req        = 1'b1;
        @(posedge clk); #1;
        rd_req        = 1'b0;
        snap = model_acc;
        exp_q.push_back({1'b0, snap[7:0]});
        exp_q.push_back({1'b1, snap[15:8]});
        check("lo_out_byte", bus.out_byte, snap[7:0]);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("hi_byte_value", bus.out_byte, snap[15:8]);
    endtask
endmodule
